// File: rtl/sel_ctrl_pkg.sv
// Shared types and helpers for the selector-chain sequencer.
package sel_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_STEP      = 3'd2,
    S_WAIT_TAIL = 3'd3,
    S_NEXT      = 3'd4,
    S_DONE      = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int max1_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sel_ctrl_timeout.sv
// Loadable down-counter with clear, enable and an expired (count==0) flag.
module sel_ctrl_timeout #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               count <= '0;
    else if (clr)             count <= '0;
    else if (load)            count <= load_val;
    else if (en && !expired)  count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/sel_chain_ctrl.sv
// Sequencer that launches go tokens into a selector chain and steps the
// neuron accumulator through WEIGHT_N weights for each of NEURON_N passes.
module sel_chain_ctrl
  import sel_ctrl_pkg::*;
#(
  parameter int WEIGHT_N = 8,
  parameter int NEURON_N = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              freeze,
  input  logic                              chain_done,
  output logic                              go_l,
  output logic                              go_r,
  output logic                              acc_clr,
  output logic                              acc_en,
  output logic [max1_clog2(WEIGHT_N)-1:0]   weight_idx,
  output logic [max1_clog2(NEURON_N)-1:0]   neuron_idx,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout_err
);

  localparam int WW = max1_clog2(WEIGHT_N);
  localparam int NW = max1_clog2(NEURON_N);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] W_LAST = WW'(WEIGHT_N - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NEURON_N - 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic [WW-1:0] w_cnt;
  logic [NW-1:0] n_cnt;
  logic          early;
  logic          tmr_expired;

  logic go_l_d, go_r_d, acc_clr_d, acc_en_d, busy_d, done_d, err_d;

  // Counter is armed during STEP so WAIT_TAIL starts at TIMEOUT-1 and
  // expires after exactly TIMEOUT cycles without a tail token.
  sel_ctrl_timeout #(.WIDTH(TW)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == S_IDLE),
    .load     (state == S_STEP),
    .en       (state == S_WAIT_TAIL),
    .load_val (T_LOAD),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:      if (start) state_nx = S_LAUNCH;
      S_LAUNCH:    state_nx = S_STEP;
      S_STEP:      if (!freeze && w_cnt == W_LAST) state_nx = S_WAIT_TAIL;
      S_WAIT_TAIL: begin
        if (early || chain_done) state_nx = S_NEXT;
        else if (tmr_expired)    state_nx = S_ERR;
      end
      S_NEXT:      state_nx = (n_cnt == N_LAST) ? S_DONE : S_LAUNCH;
      S_DONE:      state_nx = S_IDLE;
      S_ERR:       if (start) state_nx = S_LAUNCH;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt <= '0;
      n_cnt <= '0;
      early <= 1'b0;
    end else begin
      if (state_nx == S_LAUNCH)
        w_cnt <= '0;
      else if (state == S_STEP && !freeze && w_cnt != W_LAST)
        w_cnt <= w_cnt + 1'b1;

      if ((state == S_IDLE || state == S_ERR) && start)
        n_cnt <= '0;
      else if (state == S_NEXT && n_cnt != N_LAST)
        n_cnt <= n_cnt + 1'b1;

      // A tail that overtakes the stepping is remembered for WAIT_TAIL.
      if (state == S_LAUNCH)                  early <= chain_done;
      else if (state == S_STEP && chain_done) early <= 1'b1;
    end
  end

  always_comb begin
    go_l_d    = 1'b0;
    go_r_d    = 1'b0;
    acc_clr_d = 1'b0;
    acc_en_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state)
      S_LAUNCH: begin
        go_l_d    = 1'b1;
        go_r_d    = (n_cnt != '0);
        acc_clr_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_STEP: begin
        acc_en_d = !freeze;
        busy_d   = 1'b1;
      end
      S_WAIT_TAIL, S_NEXT: busy_d = 1'b1;
      S_DONE:              done_d = 1'b1;
      S_ERR:               err_d  = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs keep inputs off any combinational output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_l        <= 1'b0;
      go_r        <= 1'b0;
      acc_clr     <= 1'b0;
      acc_en      <= 1'b0;
      weight_idx  <= '0;
      neuron_idx  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      go_l        <= go_l_d;
      go_r        <= go_r_d;
      acc_clr     <= acc_clr_d;
      acc_en      <= acc_en_d;
      weight_idx  <= w_cnt;
      neuron_idx  <= n_cnt;
      busy        <= busy_d;
      done        <= done_d;
      timeout_err <= err_d;
    end
  end

endmodule
